pulse_period_meter: RTL and testbench

- Consumes a periodic strobe, such as the single-cycle enable from the clock-enable generator or an external pin, and measures the clock-cycle count between consecutive events.
- Each measurement goes through a valid/ready result port.
- Flags cover back-pressure overrun and a missing-pulse timeout.
- Used in self-check logic to verify generated rates and to measure external signal periods.

---
 rtl/pulse_period_meter.sv | 138 +++++++++++++
 tb/tb_pulse_period_meter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the clock-cycle spacing between consecutive strobe events and
// reports each result over a valid/ready port with sticky overrun/timeout flags.
module pulse_period_meter #(
    parameter int unsigned  CLKFREQ    = 100_000_000,
    parameter int unsigned  MAX_PERIOD = 100_000_000,
    parameter bit           SYNC_EN    = 1'b1,
    localparam int unsigned W          = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         pulse_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    input  logic         period_ready,
    output logic         overrun,
    output logic         timeout
);

    if (MAX_PERIOD < 2 || CLKFREQ == 0) begin : g_bad_params
        $error("pulse_period_meter: MAX_PERIOD must be >= 2 and CLKFREQ nonzero");
    end

    logic evt;

    // Asynchronous input: two-flop synchronizer followed by rising-edge detect.
    if (SYNC_EN) begin : g_sync
        logic s1_q, s2_q, s3_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                s3_q <= 1'b0;
            end else begin
                s1_q <= pulse_in;
                s2_q <= s1_q;
                s3_q <= s2_q;
            end
        end

        assign evt = s2_q & ~s3_q;
    end else begin : g_direct
        assign evt = pulse_in;
    end

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;
    logic         timeout_q, timeout_d;
    logic [W-1:0] cnt_inc;

    // Next-state: counting, result hand-off and flag updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        cnt_inc   = cnt_q + W'(1);

        if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end

        if (clr) begin
            state_d   = IDLE;
            cnt_d     = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (evt) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (evt) begin
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        // A held, unaccepted result wins; the new one is dropped.
                        if (!valid_q || period_ready) begin
                            period_d = cnt_inc;
                            valid_d  = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else if (cnt_inc == W'(MAX_PERIOD)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: synchronous strobes, synchronized
// square wave, back-pressure, timeout, held-high input, rst and clr.
module tb_pulse_period_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // dut0: synchronous strobe, default MAX_PERIOD
    logic        clr0 = 1'b0, pulse0 = 1'b0, ready0 = 1'b1;
    logic [26:0] period0;
    logic        valid0, overrun0, timeout0;
    // dut1: asynchronous input through the synchronizer
    logic        clr1 = 1'b0, pulse1 = 1'b0, ready1 = 1'b1;
    logic [26:0] period1;
    logic        valid1, overrun1, timeout1;
    // dut2: synchronous strobe, MAX_PERIOD = 64
    logic        clr2 = 1'b0, pulse2 = 1'b0, ready2 = 1'b1;
    logic [6:0]  period2;
    logic        valid2, overrun2, timeout2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.CLKFREQ(100_000_000), .MAX_PERIOD(100_000_000), .SYNC_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr0), .pulse_in(pulse0), .period(period0),
        .period_valid(valid0), .period_ready(ready0), .overrun(overrun0), .timeout(timeout0));

    pulse_period_meter #(.CLKFREQ(100_000_000), .MAX_PERIOD(100_000_000), .SYNC_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .pulse_in(pulse1), .period(period1),
        .period_valid(valid1), .period_ready(ready1), .overrun(overrun1), .timeout(timeout1));

    pulse_period_meter #(.CLKFREQ(100_000_000), .MAX_PERIOD(64), .SYNC_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr2), .pulse_in(pulse2), .period(period2),
        .period_valid(valid2), .period_ready(ready2), .overrun(overrun2), .timeout(timeout2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe0();
        pulse0 = 1'b1;
        tick();
        pulse0 = 1'b0;
    endtask

    task automatic strobe2();
        pulse2 = 1'b1;
        tick();
        pulse2 = 1'b0;
    endtask

    task automatic clear0();
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({period0, valid0, overrun0, timeout0} !== 30'd0)
            $display("FAIL reset_outputs: got period=%0d valid=%b ovr=%b to=%b, want all 0",
                     period0, valid0, overrun0, timeout0);
        else passed++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sync_strobe();
        int bad_between = 0;
        for (int k = 0; k < 4; k++) begin
            strobe0();
            checks++;
            if (k == 0 && valid0 !== 1'b0)
                $display("FAIL strobe_first_no_valid: got valid=%b, want 0", valid0);
            else if (k > 0 && (valid0 !== 1'b1 || period0 !== 27'd1000))
                $display("FAIL strobe_period_%0d: got valid=%b period=%0d, want 1/1000", k, valid0, period0);
            else passed++;
            for (int i = 0; i < 999; i++) begin
                tick();
                if (valid0 !== 1'b0) bad_between++;
            end
        end
        checks++;
        if (bad_between != 0)
            $display("FAIL strobe_valid_one_cycle: got %0d extra valid cycles, want 0", bad_between);
        else passed++;
        checks++;
        if (overrun0 !== 1'b0 || timeout0 !== 1'b0)
            $display("FAIL strobe_flags: got ovr=%b to=%b, want 0/0", overrun0, timeout0);
        else passed++;
    endtask

    task automatic test_async_square();
        for (int p = 0; p < 4; p++) begin
            #3 pulse1 = 1'b1;
            for (int i = 1; i <= 100; i++) begin
                tick();
                if (i == 37) pulse1 = 1'b0;
                if (i == 2) begin
                    checks++;
                    if (valid1 !== 1'b0)
                        $display("FAIL async_lag_%0d: got valid=%b at 2nd edge, want 0", p, valid1);
                    else passed++;
                end
                if (i == 3) begin
                    checks++;
                    if (p == 0 && valid1 !== 1'b0)
                        $display("FAIL async_first_no_valid: got valid=%b, want 0", valid1);
                    else if (p > 0 && (valid1 !== 1'b1 || period1 !== 27'd100))
                        $display("FAIL async_period_%0d: got valid=%b period=%0d, want 1/100", p, valid1, period1);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        clear0();
        ready0 = 1'b0;
        strobe0();
        repeat (49) tick();
        strobe0();
        checks++;
        if (valid0 !== 1'b1 || period0 !== 27'd50 || overrun0 !== 1'b0)
            $display("FAIL bp_first: got valid=%b period=%0d ovr=%b, want 1/50/0", valid0, period0, overrun0);
        else passed++;
        repeat (29) tick();
        strobe0();
        checks++;
        if (valid0 !== 1'b1 || period0 !== 27'd50 || overrun0 !== 1'b1)
            $display("FAIL bp_dropped: got valid=%b period=%0d ovr=%b, want 1/50/1", valid0, period0, overrun0);
        else passed++;
        repeat (5) tick();
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        checks++;
        if (valid0 !== 1'b0 || overrun0 !== 1'b1)
            $display("FAIL bp_accept: got valid=%b ovr=%b, want 0/1", valid0, overrun0);
        else passed++;
        clear0();
        checks++;
        if (overrun0 !== 1'b0)
            $display("FAIL bp_clr_overrun: got ovr=%b, want 0", overrun0);
        else passed++;
        ready0 = 1'b1;
    endtask

    task automatic test_timeout();
        strobe2();
        repeat (63) tick();
        checks++;
        if (timeout2 !== 1'b0)
            $display("FAIL timeout_early: got to=%b at 63 cycles, want 0", timeout2);
        else passed++;
        tick();
        checks++;
        if (timeout2 !== 1'b1)
            $display("FAIL timeout_at_64: got to=%b, want 1", timeout2);
        else passed++;
        repeat (3) tick();
        strobe2();
        checks++;
        if (valid2 !== 1'b0 || timeout2 !== 1'b1)
            $display("FAIL timeout_idle_first_event: got valid=%b to=%b, want 0/1", valid2, timeout2);
        else passed++;
        repeat (9) tick();
        strobe2();
        checks++;
        if (valid2 !== 1'b1 || period2 !== 7'd10 || timeout2 !== 1'b0)
            $display("FAIL timeout_recover: got valid=%b period=%0d to=%b, want 1/10/0", valid2, period2, timeout2);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clear0();
        ready0 = 1'b1;
        pulse0 = 1'b1;
        tick();
        checks++;
        if (valid0 !== 1'b0)
            $display("FAIL held_first: got valid=%b, want 0", valid0);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid0 !== 1'b1 || period0 !== 27'd1 || overrun0 !== 1'b0)
                $display("FAIL held_cycle_%0d: got valid=%b period=%0d ovr=%b, want 1/1/0",
                         i, valid0, period0, overrun0);
            else passed++;
        end
        pulse0 = 1'b0;
        tick();
    endtask

    task automatic test_rst_and_clr();
        clear0();
        ready0 = 1'b0;
        strobe0();
        repeat (9) tick();
        strobe0();
        repeat (9) tick();
        strobe0();
        repeat (499) tick();
        checks++;
        if (valid0 !== 1'b1 || overrun0 !== 1'b1)
            $display("FAIL rst_setup: got valid=%b ovr=%b, want 1/1", valid0, overrun0);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({period0, valid0, overrun0, timeout0} !== 30'd0)
            $display("FAIL rst_async_clear: got period=%0d valid=%b ovr=%b to=%b, want all 0",
                     period0, valid0, overrun0, timeout0);
        else passed++;
        tick();
        rst = 1'b0;
        ready0 = 1'b1;
        tick();
        strobe0();
        checks++;
        if (valid0 !== 1'b0)
            $display("FAIL rst_first_event: got valid=%b, want 0", valid0);
        else passed++;
        repeat (4) tick();
        strobe0();
        checks++;
        if (valid0 !== 1'b1 || period0 !== 27'd5)
            $display("FAIL rst_remeasure: got valid=%b period=%0d, want 1/5", valid0, period0);
        else passed++;
        repeat (5) tick();
        pulse0 = 1'b1;
        clr0 = 1'b1;
        tick();
        pulse0 = 1'b0;
        clr0 = 1'b0;
        checks++;
        if (valid0 !== 1'b0)
            $display("FAIL clr_event_no_result: got valid=%b, want 0", valid0);
        else passed++;
        repeat (3) tick();
        strobe0();
        checks++;
        if (valid0 !== 1'b0)
            $display("FAIL clr_idle_first_event: got valid=%b, want 0", valid0);
        else passed++;
        repeat (2) tick();
        strobe0();
        checks++;
        if (valid0 !== 1'b1 || period0 !== 27'd3)
            $display("FAIL clr_remeasure: got valid=%b period=%0d, want 1/3", valid0, period0);
        else passed++;
    endtask

    initial begin
        test_reset();
        fork
            test_sync_strobe();
            test_async_square();
            test_timeout();
        join
        test_back_pressure();
        test_back_to_back();
        test_rst_and_clr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
